// File: rtl/pixel_scan_counter.sv
// Raster-order (x fastest) 2-D scan counter with valid/ready output.
// Latches frame bounds on start, counts completed frames.
module pixel_scan_counter #(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  start,
  input  logic [X_BITS-1:0]     x_last,
  input  logic [Y_BITS-1:0]     y_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [X_BITS-1:0]     x,
  output logic [Y_BITS-1:0]     y,
  output logic                  last_in_row,
  output logic                  last_in_frame,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_n;
  logic [X_BITS-1:0]     xl, xl_n, x_n;
  logic [Y_BITS-1:0]     yl, yl_n, y_n;
  logic [FRAME_BITS-1:0] fc_n;
  logic                  done_n;
  logic                  hs;

  assign out_valid     = (state == RUN);
  assign busy          = out_valid;
  assign last_in_row   = out_valid && (x == xl);
  assign last_in_frame = last_in_row && (y == yl);
  assign hs            = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      xl          <= '0;
      yl          <= '0;
      frame_count <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      xl          <= xl_n;
      yl          <= yl_n;
      frame_count <= fc_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    xl_n    = xl;
    yl_n    = yl;
    fc_n    = frame_count;
    done_n  = 1'b0;
    if (clr) begin
      // abort: no done pulse, counter cleared
      state_n = IDLE;
      x_n     = '0;
      y_n     = '0;
      fc_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xl_n    = x_last;
            yl_n    = y_last;
            x_n     = '0;
            y_n     = '0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (x != xl) begin
              x_n = x + X_BITS'(1);
            end else if (y != yl) begin
              x_n = '0;
              y_n = y + Y_BITS'(1);
            end else begin
              x_n     = '0;
              y_n     = '0;
              state_n = IDLE;
              fc_n    = frame_count + FRAME_BITS'(1);
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
